// File: rtl/median_pkg.sv
// Shared types and constants for the median window sink.
// Optional feature macro: ADAPTIVE_MEDIAN_EN (see median_window_sink.sv).
package median_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned COORD_W = 10;

  localparam logic [PIX_W-1:0] SALT   = 8'd255;
  localparam logic [PIX_W-1:0] PEPPER = 8'd0;

endpackage

// File: rtl/median_window_sink_sort3.sv
// Combinational min/mid/max of three unsigned pixels.
module sort3
  import median_pkg::*;
(
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  input  logic [PIX_W-1:0] c,
  output logic [PIX_W-1:0] lo,
  output logic [PIX_W-1:0] mid,
  output logic [PIX_W-1:0] hi
);

  logic [PIX_W-1:0] lo_ab, hi_ab, hi_ab_c_lo;

  always_comb begin
    lo_ab      = (a < b) ? a : b;
    hi_ab      = (a < b) ? b : a;
    hi_ab_c_lo = (hi_ab < c) ? hi_ab : c;
    lo         = (lo_ab < c) ? lo_ab : c;
    hi         = (hi_ab < c) ? c : hi_ab;
    mid        = (lo_ab < hi_ab_c_lo) ? hi_ab_c_lo : lo_ab;
  end

endmodule

// File: rtl/median_window_sink.sv
// 3x3 window consumer: 3-stage median sorting network, raster order check, frame done.
// Optional: define ADAPTIVE_MEDIAN_EN to filter only salt/pepper centres.
module median_window_sink
  import median_pkg::*;
#(
  parameter int unsigned WIDTH  = 430,
  parameter int unsigned HEIGHT = 554,
  parameter int unsigned CNT_W  = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               win_valid,
  output logic               win_ready,
  input  logic [COORD_W-1:0] Row_i,
  input  logic [COORD_W-1:0] Col_i,
  input  logic [PIX_W-1:0]   D0,
  input  logic [PIX_W-1:0]   D1,
  input  logic [PIX_W-1:0]   D2,
  input  logic [PIX_W-1:0]   D3,
  input  logic [PIX_W-1:0]   D4,
  input  logic [PIX_W-1:0]   D5,
  input  logic [PIX_W-1:0]   D6,
  input  logic [PIX_W-1:0]   D7,
  input  logic [PIX_W-1:0]   D8,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [PIX_W-1:0]   pix_data,
  output logic [COORD_W-1:0] pix_row,
  output logic [COORD_W-1:0] pix_col,
  output logic               seq_err,
  output logic               done
);

  localparam int unsigned        TOTAL    = WIDTH * HEIGHT;
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(WIDTH - 1);

  state_t state, state_nxt;

  logic en, accept, out_hs, arm;
  logic [CNT_W-1:0]   in_cnt, out_cnt;
  logic [COORD_W-1:0] exp_row, exp_col;

  logic [PIX_W-1:0] d_in [9];
  logic [PIX_W-1:0] t_lo [3], t_mid [3], t_hi [3];
  logic [PIX_W-1:0] s1_lo [3], s1_mid [3], s1_hi [3];
  logic             s1_valid, s2_valid;
  logic [COORD_W-1:0] s1_row, s1_col, s2_row, s2_col;
  logic [PIX_W-1:0] s2_a_d, s2_b_d, s2_c_d, s2_a, s2_b, s2_c;
  logic [PIX_W-1:0] med, s3_d;
  logic [PIX_W-1:0] unused_s2 [6];
  logic [PIX_W-1:0] unused_s3 [2];
`ifdef ADAPTIVE_MEDIAN_EN
  logic [PIX_W-1:0] s1_ctr, s2_ctr;
`endif

  assign en     = !pix_valid || pix_ready;
  assign accept = win_valid && win_ready;
  assign out_hs = pix_valid && pix_ready;
  assign arm    = start && (state == IDLE || state == DONE);

  always_comb begin
    d_in[0] = D0; d_in[1] = D1; d_in[2] = D2;
    d_in[3] = D3; d_in[4] = D4; d_in[5] = D5;
    d_in[6] = D6; d_in[7] = D7; d_in[8] = D8;
  end

  for (genvar g = 0; g < 3; g++) begin : g_s1
    sort3 u_row_sort (
      .a(d_in[3*g]), .b(d_in[3*g+1]), .c(d_in[3*g+2]),
      .lo(t_lo[g]), .mid(t_mid[g]), .hi(t_hi[g])
    );
  end

  sort3 u_s2_lo (.a(s1_lo[0]), .b(s1_lo[1]), .c(s1_lo[2]),
                 .lo(unused_s2[0]), .mid(unused_s2[1]), .hi(s2_a_d));
  sort3 u_s2_mid (.a(s1_mid[0]), .b(s1_mid[1]), .c(s1_mid[2]),
                  .lo(unused_s2[2]), .mid(s2_b_d), .hi(unused_s2[3]));
  sort3 u_s2_hi (.a(s1_hi[0]), .b(s1_hi[1]), .c(s1_hi[2]),
                 .lo(s2_c_d), .mid(unused_s2[4]), .hi(unused_s2[5]));
  sort3 u_s3 (.a(s2_a), .b(s2_b), .c(s2_c),
              .lo(unused_s3[0]), .mid(med), .hi(unused_s3[1]));

  // Adaptive build keeps non-impulse centres untouched; latency is unchanged.
  always_comb begin
`ifdef ADAPTIVE_MEDIAN_EN
    s3_d = (s2_ctr == SALT || s2_ctr == PEPPER) ? med : s2_ctr;
`else
    s3_d = med;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      pix_valid <= 1'b0;
      s1_lo     <= '{default: '0};
      s1_mid    <= '{default: '0};
      s1_hi     <= '{default: '0};
      s1_row    <= '0;
      s1_col    <= '0;
      s2_a      <= '0;
      s2_b      <= '0;
      s2_c      <= '0;
      s2_row    <= '0;
      s2_col    <= '0;
      pix_data  <= '0;
      pix_row   <= '0;
      pix_col   <= '0;
`ifdef ADAPTIVE_MEDIAN_EN
      s1_ctr    <= '0;
      s2_ctr    <= '0;
`endif
    end else if (en) begin
      s1_valid  <= accept;
      s2_valid  <= s1_valid;
      pix_valid <= s2_valid;
      if (accept) begin
        s1_lo  <= t_lo;
        s1_mid <= t_mid;
        s1_hi  <= t_hi;
        s1_row <= Row_i;
        s1_col <= Col_i;
`ifdef ADAPTIVE_MEDIAN_EN
        s1_ctr <= D4;
`endif
      end
      if (s1_valid) begin
        s2_a   <= s2_a_d;
        s2_b   <= s2_b_d;
        s2_c   <= s2_c_d;
        s2_row <= s1_row;
        s2_col <= s1_col;
`ifdef ADAPTIVE_MEDIAN_EN
        s2_ctr <= s1_ctr;
`endif
      end
      if (s2_valid) begin
        pix_data <= s3_d;
        pix_row  <= s2_row;
        pix_col  <= s2_col;
      end
    end
  end

  // Expected coordinates track the ideal raster sequence, not what arrived.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt  <= '0;
      out_cnt <= '0;
      exp_row <= '0;
      exp_col <= '0;
      seq_err <= 1'b0;
    end else if (arm) begin
      in_cnt  <= '0;
      out_cnt <= '0;
      exp_row <= '0;
      exp_col <= '0;
      seq_err <= 1'b0;
    end else begin
      if (accept) begin
        in_cnt <= in_cnt + CNT_W'(1);
        if (Row_i != exp_row || Col_i != exp_col) seq_err <= 1'b1;
        if (exp_col == LAST_COL) begin
          exp_col <= '0;
          exp_row <= exp_row + COORD_W'(1);
        end else begin
          exp_col <= exp_col + COORD_W'(1);
        end
      end
      if (out_hs) out_cnt <= out_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (accept && in_cnt == LAST_CNT) state_nxt = DRAIN;
      DRAIN: if (out_hs && out_cnt == LAST_CNT) state_nxt = DONE;
      DONE:  if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    win_ready = en && (state == RUN);
    done      = (state == DONE);
  end

endmodule

// File: doc/median_window_sink.md
Name: median_window_sink

Overview:
- Consumer end of the 3x3 window stream produced by the filter top. Accepts one window (D0..D8 plus its Row/Col) per handshake.
- Computes the median through a 3-stage pipelined sorting network and emits the filtered pixel as a raster-ordered stream with coordinates.
- Counts output pixels, checks that window coordinates arrive in raster order, and asserts done after WIDTH*HEIGHT pixels.

Parameters:
- WIDTH, 430, image columns (Col range 0..WIDTH-1).
- HEIGHT, 554, image rows (Row range 0..HEIGHT-1).
- CNT_W, 18, pixel counter width; must satisfy 2^CNT_W > WIDTH*HEIGHT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; arms a new frame.
- win_valid  in  1  window D0..D8/Row_i/Col_i is valid.
- win_ready  out  1  block accepts the window this cycle.
- Row_i  in  10  window centre row.
- Col_i  in  10  window centre column.
- D0..D8  in  8 each  window pixels, row-major; D4 is the centre.
- pix_valid  out  1  output pixel valid.
- pix_ready  in  1  downstream accepts the pixel.
- pix_data  out  8  filtered pixel.
- pix_row  out  10  row of pix_data.
- pix_col  out  10  column of pix_data.
- seq_err  out  1  sticky; window coordinates out of raster order.
- done  out  1  frame complete; level until next start.

Behaviour:
- Reset (async, active-high): FSM=IDLE, win_ready=0, pix_valid=0, pix_data=0, pix_row=0, pix_col=0, seq_err=0, done=0, all counters 0, pipeline valid bits 0.
- FSM states: IDLE -> RUN on start. RUN -> DRAIN when the WIDTH*HEIGHT-th window is accepted. DRAIN -> DONE when the WIDTH*HEIGHT-th pixel handshake completes. DONE -> RUN on start.
- start is ignored in RUN and DRAIN. start in IDLE or DONE clears done, seq_err and all counters.
- Global pipeline enable: en = !pix_valid || pix_ready. win_ready = en && (state==RUN).
- Input accept = win_valid && win_ready. Output handshake = pix_valid && pix_ready.
- Pipeline, latency 3 cycles from accept to pix_valid with no stall:
  - S1: sort each triple (D0,D1,D2), (D3,D4,D5), (D6,D7,D8) ascending.
  - S2: max of the three minima; median of the three middles; min of the three maxima.
  - S3: median of the three S2 results, registered into pix_data.
- Row and column travel with the data through all stages. A stall freezes every stage. Bubbles propagate as valid=0.
- Throughput: 1 pixel/cycle while pix_ready=1.
- Arithmetic is unsigned 8-bit compare only; there is no widening.
- Order check: expected (row, col) counter starts at (0,0) and advances on each accept. col wraps at WIDTH-1 to 0 and increments row.
  - Mismatch on accept sets seq_err (sticky). The window is still processed. The expected counter follows the expected sequence, not the received coordinates.
- Output counter increments on each pixel handshake. done=1 in DONE.
- Simultaneous final accept and an output handshake in the same cycle: both take effect.
- win_valid in IDLE, DRAIN or DONE: ignored (win_ready=0).
- pix_valid, once high, holds pix_data/pix_row/pix_col stable until pix_ready.
- Reset mid-frame: all in-flight pixels are discarded and the block returns to IDLE immediately.

Optional Feature:
- Macro: ADAPTIVE_MEDIAN_EN.
- Defined: S3 outputs the median only when the centre D4 (carried down the pipeline) is 0 or 255. Otherwise it outputs D4 unchanged.
- Undefined: S3 always outputs the median.
- Latency is identical in both builds.

Decomposition:
- Shared package median_pkg:
  - State encoding IDLE=0, RUN=1, DRAIN=2, DONE=3.
  - PIX_W=8, COORD_W=10.
  - Noise levels SALT=255, PEPPER=0.
- Sub-module sort3: combinational min/mid/max of three 8-bit values. Instantiated 3x in S1 and reused for the S2/S3 medians.

Test Plan (WIDTH=4, HEIGHT=3 for frame tests):
- Window D0..D8 = 9,1,8,2,7,3,6,4,5, pix_ready=1 -> pix_data=5 exactly 3 cycles after accept; coordinates echoed.
- Centre D4=255, others 10..17 -> pix_data=14. With ADAPTIVE_MEDIAN_EN and centre D4=100 -> pix_data=100.
- Full 12-window frame, raster coordinates, pix_ready=1 -> 12 pixels in order (0,0)..(2,3); done=1 on the cycle after the 12th handshake; seq_err=0.
- pix_ready low for 5 cycles mid-frame -> win_ready=0 during the stall; no pixel lost or duplicated; pix_data held stable.
- Second window sent with Col_i=2 instead of 1 -> seq_err=1 from the next cycle; it stays set until start.
- rst asserted with 2 pixels in flight -> all outputs zero asynchronously; a new start runs a clean frame.
